eth_tx_arbiter: RTL and testbench
=================================

# eth_tx_arbiter

Packet-level N-channel arbiter that merges Avalon-ST-style packet sources (ARP, UDP, ping, and future generators) onto the single 32-bit Ethernet TX stream. It replaces the externally-steered packet-type mux with self-contained round-robin arbitration. Once a channel is granted, the arbiter locks onto it from SOP to EOP, so packets are never interleaved. It sits between the packet builders and the MAC TX interface.

## Interface
- NUM_CH, 3, number of input channels (2..8)
- DATA_W, 32, data width per beat
- CH_W, $clog2(NUM_CH) (min 1), width of channel index

- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ch_data  in  NUM_CH*DATA_W  channel data; channel k occupies bits [k*DATA_W +: DATA_W]
- i_ch_sop  in  NUM_CH  start of packet, one bit per channel
- i_ch_eop  in  NUM_CH  end of packet, one bit per channel
- i_ch_vld  in  NUM_CH  beat valid, one bit per channel
- o_ch_rdy  out  NUM_CH  beat accepted from channel k when i_ch_vld[k] & o_ch_rdy[k]
- o_tx_data  out  DATA_W  to Ethernet MAC
- o_tx_sop  out  1  start of packet
- o_tx_eop  out  1  end of packet
- o_tx_vld  out  1  beat valid
- i_tx_rdy  in  1  MAC ready
- o_busy  out  1  high while a packet is locked
- o_cur_ch  out  CH_W  index of the granted or last-granted channel
- o_pkt_cnt  out  NUM_CH*16  per-channel forwarded-packet counters (see Configuration)
- o_drop_cnt  out  16  orphan-beat drop counter (see Configuration)

## Operation
- States: IDLE, BUSY. Registered state: state, cur_ch, rr_ptr.
- IDLE:
  - req[k] = i_ch_vld[k] & i_ch_sop[k].
  - If any req bit is set, grant the first set bit found scanning upward from rr_ptr, wrapping modulo NUM_CH.
  - On the next edge: cur_ch <= grant, state <= BUSY. No beat is accepted in the arbitration cycle.
- Orphans in IDLE:
  - Channels with i_ch_vld & ~i_ch_sop get o_ch_rdy = 1; their beats are discarded (flushed).
  - Each discarded beat increments the drop counter.
  - o_tx_vld = 0 throughout IDLE.
- BUSY:
  - o_tx_{data,sop,eop,vld} are driven combinationally from channel cur_ch.
  - o_ch_rdy[cur_ch] = i_tx_rdy; all other o_ch_rdy bits are 0.
  - Transfer occurs when i_ch_vld[cur_ch] & i_tx_rdy.
  - Transfer with eop: state <= IDLE, rr_ptr <= (cur_ch+1) mod NUM_CH, and pkt_cnt[cur_ch] increments.
- sop seen mid-packet on the locked channel is forwarded unchanged; only eop ends the lock.
- A single-beat packet (sop & eop together) is accepted and the arbiter returns to IDLE after that one beat.
- Non-granted channels are held (rdy = 0) during BUSY; their orphan beats are not flushed in BUSY.
- Outside IDLE/BUSY driving rules: o_tx_data = 0, o_tx_sop = 0, o_tx_eop = 0.
- Counters are 16 bits and wrap from 0xFFFF to 0x0000.

## Timing
- Reset values: state IDLE, cur_ch 0, rr_ptr 0, o_busy 0, o_tx_vld 0, o_tx_sop 0, o_tx_eop 0, o_tx_data 0, o_ch_rdy all 0, all counters 0.
- Arbitration latency: SOP presented in cycle n, first beat on o_tx in cycle n+1.
- Data path, BUSY: zero latency, combinational from the channel to o_tx; i_tx_rdy to o_ch_rdy is combinational.
- Inter-packet gap: at least one IDLE cycle after every EOP transfer.
- Stall: i_tx_rdy low holds the lock indefinitely; there is no timeout.
- o_busy = (state == BUSY); o_cur_ch = cur_ch register.
- Reset asserted mid-packet: everything returns to IDLE immediately (asynchronous). The partial packet is abandoned; the source must restart with SOP.

## Configuration
- ETH_TX_ARB_STATS_EN defined:
  - o_pkt_cnt and o_drop_cnt are live counters, as described above.
- ETH_TX_ARB_STATS_EN undefined:
  - Counter registers are not built; o_pkt_cnt and o_drop_cnt are tied to 0.
  - Ports remain, so instantiations are unchanged.
  - Orphan flushing still happens.

## Test plan
- Single channel: ch1 sends 4 beats (0xA0..0xA3), i_tx_rdy = 1 → o_tx shows 0xA0..0xA3, one cycle after the ch1 SOP, with sop on beat 0 and eop on beat 3; o_busy falls after beat 3; pkt_cnt[1] = 1.
- Round-robin fairness: all 3 channels continuously offer 2-beat packets → grant order 0, 1, 2, 0, 1, 2; no interleaving; one idle cycle between packets.
- Backpressure: i_tx_rdy toggles every cycle during a 5-beat ch2 packet → every beat is transferred exactly once; o_ch_rdy[2] follows i_tx_rdy; other rdy bits stay 0.
- Orphan flush: ch0 presents vld without sop for 3 cycles while IDLE → o_ch_rdy[0] = 1 for those cycles, o_tx_vld stays 0, drop_cnt = 3 (0 with the macro off).
- Single-beat packets: ch0 and ch1 both present sop & eop simultaneously with rr_ptr = 1 → ch1 is sent first, then ch0; both pkt_cnt entries = 1.
- Reset mid-packet: i_rst_n is pulled low after beat 2 of 4 on ch0 → o_tx_vld = 0 and o_busy = 0 at once; after release, a fresh ch0 SOP is granted normally.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Packet-level round-robin arbiter. It merges NUM_CH Avalon-ST-style packet
// sources onto one Ethernet TX stream. A granted channel stays locked from SOP
// to EOP, so packets from different sources are never interleaved.
//
// Optional feature macro: ETH_TX_ARB_STATS_EN
//   When defined, o_pkt_cnt and o_drop_cnt are live 16-bit wrapping counters.
//   When undefined, no counter registers are built and both ports read 0.
//   Orphan flushing happens in both builds.
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_ch_data      : per-channel beat data, channel k at [k*DATA_W +: DATA_W]
//   i_ch_sop/eop   : per-channel start/end of packet flags
//   i_ch_vld       : per-channel beat valid
//   o_ch_rdy       : per-channel ready (a beat moves when vld & rdy)
//   o_tx_*         : merged stream toward the MAC; i_tx_rdy is the MAC ready
//   o_busy         : high while a packet is locked
//   o_cur_ch       : granted or last-granted channel
//   o_pkt_cnt      : per-channel forwarded-packet counters, 16 bits each
//   o_drop_cnt     : count of orphan beats discarded while idle
module eth_tx_arbiter #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  input  logic [NUM_CH-1:0]        i_ch_sop,
  input  logic [NUM_CH-1:0]        i_ch_eop,
  input  logic [NUM_CH-1:0]        i_ch_vld,
  output logic [NUM_CH-1:0]        o_ch_rdy,
  output logic [DATA_W-1:0]        o_tx_data,
  output logic                     o_tx_sop,
  output logic                     o_tx_eop,
  output logic                     o_tx_vld,
  input  logic                     i_tx_rdy,
  output logic                     o_busy,
  output logic [CH_W-1:0]          o_cur_ch,
  output logic [NUM_CH*16-1:0]     o_pkt_cnt,
  output logic [15:0]              o_drop_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] flush;
  logic              grant_vld;
  logic [CH_W-1:0]   grant;
  int                scan_idx;

  logic [DATA_W-1:0] sel_data;
  logic              sel_sop, sel_eop, sel_vld;
  logic              xfer_eop;

  // Round-robin search: first requesting channel at or above rr_ptr, wrapping.
  always_comb begin
    req       = i_ch_vld & i_ch_sop;
    flush     = i_ch_vld & ~i_ch_sop;
    grant_vld = 1'b0;
    grant     = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!grant_vld && req[scan_idx]) begin
        grant_vld = 1'b1;
        grant     = CH_W'(scan_idx);
      end
    end
  end

  // Locked-channel mux, written as a compare loop so an unused cur_ch
  // encoding (non power-of-two NUM_CH) simply selects nothing.
  always_comb begin
    sel_data = '0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_vld  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == cur_ch_q) begin
        sel_data = i_ch_data[k*DATA_W +: DATA_W];
        sel_sop  = i_ch_sop[k];
        sel_eop  = i_ch_eop[k];
        sel_vld  = i_ch_vld[k];
      end
    end
  end

  assign xfer_eop = (state_q == ST_BUSY) & sel_vld & i_tx_rdy & sel_eop;

  // Output steering: idle flushes orphans and never presents a beat; busy
  // passes the locked channel straight through with MAC ready fed back.
  always_comb begin
    o_tx_data = '0;
    o_tx_sop  = 1'b0;
    o_tx_eop  = 1'b0;
    o_tx_vld  = 1'b0;
    o_ch_rdy  = '0;
    case (state_q)
      ST_IDLE: o_ch_rdy = flush;
      ST_BUSY: begin
        o_tx_data = sel_data;
        o_tx_sop  = sel_sop;
        o_tx_eop  = sel_eop;
        o_tx_vld  = sel_vld;
        for (int k = 0; k < NUM_CH; k++) begin
          o_ch_rdy[k] = (CH_W'(k) == cur_ch_q) & i_tx_rdy;
        end
      end
      default: ;
    endcase
  end

  // Next state: the grant takes effect on the edge after arbitration, and
  // the pointer moves past the channel that just finished its packet.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          cur_ch_d = grant;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer_eop) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cur_ch_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_busy   = (state_q == ST_BUSY);
  assign o_cur_ch = cur_ch_q;

`ifdef ETH_TX_ARB_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_CH];
  logic [15:0] pkt_cnt_d [NUM_CH];
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Several channels can be flushed in the same idle cycle, so every
  // discarded beat is added individually.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (xfer_eop && (CH_W'(k) == cur_ch_q)) pkt_cnt_d[k] = pkt_cnt_q[k] + 16'd1;
      if (state_q == ST_IDLE) drop_cnt_d = drop_cnt_d + {15'd0, flush[k]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) pkt_cnt_q[k] <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pkt_cnt
    assign o_pkt_cnt[g*16 +: 16] = pkt_cnt_q[g];
  end
  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_pkt_cnt  = '0;
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter (NUM_CH = 3, DATA_W = 32).
// Per-channel source queues model the packet builders; beats leave a source
// only when vld & rdy. Expected TX beats are pushed to a scoreboard in the
// order the arbiter should forward them and popped as they appear on o_tx.
module tb_eth_tx_arbiter;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;
  localparam int CH_W   = 2;

  logic                     i_clk;
  logic                     i_rst_n;
  logic [NUM_CH*DATA_W-1:0] i_ch_data;
  logic [NUM_CH-1:0]        i_ch_sop;
  logic [NUM_CH-1:0]        i_ch_eop;
  logic [NUM_CH-1:0]        i_ch_vld;
  logic [NUM_CH-1:0]        o_ch_rdy;
  logic [DATA_W-1:0]        o_tx_data;
  logic                     o_tx_sop;
  logic                     o_tx_eop;
  logic                     o_tx_vld;
  logic                     i_tx_rdy;
  logic                     o_busy;
  logic [CH_W-1:0]          o_cur_ch;
  logic [NUM_CH*16-1:0]     o_pkt_cnt;
  logic [15:0]              o_drop_cnt;

  eth_tx_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ch_data (i_ch_data),
    .i_ch_sop  (i_ch_sop),
    .i_ch_eop  (i_ch_eop),
    .i_ch_vld  (i_ch_vld),
    .o_ch_rdy  (o_ch_rdy),
    .o_tx_data (o_tx_data),
    .o_tx_sop  (o_tx_sop),
    .o_tx_eop  (o_tx_eop),
    .o_tx_vld  (o_tx_vld),
    .i_tx_rdy  (i_tx_rdy),
    .o_busy    (o_busy),
    .o_cur_ch  (o_cur_ch),
    .o_pkt_cnt (o_pkt_cnt),
    .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  ch;
  } beat_t;

  beat_t       src_q [NUM_CH][$];
  beat_t       exp_q [$];
  int          n_cmp;
  int          n_err;
  int          cyc;
  int          first_sop_cyc;
  int          exp_pkt [NUM_CH];
  int          exp_drop;
  bit          gap_pending;
  bit          toggle_rdy;
  logic [NUM_CH-1:0] acc;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // With the stats macro off the counters read as zero.
  function automatic int exp_cnt(input int v);
`ifdef ETH_TX_ARB_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < NUM_CH; k++) begin
      if (src_q[k].size() > 0) begin
        i_ch_vld[k]                  = 1'b1;
        i_ch_sop[k]                  = src_q[k][0].sop;
        i_ch_eop[k]                  = src_q[k][0].eop;
        i_ch_data[k*DATA_W +: DATA_W] = src_q[k][0].data;
      end else begin
        i_ch_vld[k]                  = 1'b0;
        i_ch_sop[k]                  = 1'b0;
        i_ch_eop[k]                  = 1'b0;
        i_ch_data[k*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  // Negedge observation: gap rule after an EOP, then scoreboard pop.
  task automatic sample();
    beat_t e;
    @(negedge i_clk);
    acc = i_ch_vld & o_ch_rdy;
    if (gap_pending) begin
      n_cmp++;
      if (o_tx_vld !== 1'b0 || o_busy !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL gap_after_eop: got vld=%b busy=%b, want vld=0 busy=0 (cyc %0d)",
                 o_tx_vld, o_busy, cyc);
      end
      gap_pending = 1'b0;
    end
    if (o_tx_vld === 1'b1 && i_tx_rdy === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_beat: got data=%h ch=%0d, want no beat", o_tx_data, o_cur_ch);
      end else begin
        e = exp_q.pop_front();
        if ({o_tx_data, o_tx_sop, o_tx_eop, o_cur_ch} !== {e.data, e.sop, e.eop, e.ch}) begin
          n_err++;
          $display("[TB] FAIL tx_beat: got data=%h sop=%b eop=%b ch=%0d, want data=%h sop=%b eop=%b ch=%0d",
                   o_tx_data, o_tx_sop, o_tx_eop, o_cur_ch, e.data, e.sop, e.eop, e.ch);
        end
        if (o_tx_sop === 1'b1 && first_sop_cyc < 0) first_sop_cyc = cyc;
        if (o_tx_eop === 1'b1) gap_pending = 1'b1;
      end
    end
  endtask

  task automatic advance();
    @(posedge i_clk);
    #1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    end
    acc = '0;
    if (toggle_rdy) i_tx_rdy = ~i_tx_rdy;
    cyc++;
    drive_inputs();
  endtask

  task automatic push_pkt(input int ch, input int n, input logic [31:0] base, input bit expect_it);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + 32'(i);
      b.sop  = (i == 0);
      b.eop  = (i == n - 1);
      b.ch   = 2'(ch);
      src_q[ch].push_back(b);
    end
  endtask

  task automatic expect_pkt(input int ch, input int n, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + 32'(i);
      b.sop  = (i == 0);
      b.eop  = (i == n - 1);
      b.ch   = 2'(ch);
      exp_q.push_back(b);
    end
    exp_pkt[ch]++;
  endtask

  task automatic run_until_drained(input int budget, input string name);
    while (exp_q.size() > 0 && budget > 0) begin
      sample();
      advance();
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s_timeout: got %0d beats outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    sample();
    advance();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      src_q[k].delete();
      exp_pkt[k] = 0;
    end
    exp_q.delete();
    exp_drop    = 0;
    gap_pending = 1'b0;
    acc         = '0;
    drive_inputs();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic check_counters(input string name);
    for (int k = 0; k < NUM_CH; k++) begin
      n_cmp++;
      if (o_pkt_cnt[k*16 +: 16] !== 16'(exp_cnt(exp_pkt[k]))) begin
        n_err++;
        $display("[TB] FAIL %s_pkt_cnt%0d: got %0d, want %0d", name, k,
                 o_pkt_cnt[k*16 +: 16], exp_cnt(exp_pkt[k]));
      end
    end
    n_cmp++;
    if (o_drop_cnt !== 16'(exp_cnt(exp_drop))) begin
      n_err++;
      $display("[TB] FAIL %s_drop_cnt: got %0d, want %0d", name, o_drop_cnt, exp_cnt(exp_drop));
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({o_busy, o_tx_vld, o_tx_sop, o_tx_eop} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got busy/vld/sop/eop=%b, want 0000",
               {o_busy, o_tx_vld, o_tx_sop, o_tx_eop});
    end
    n_cmp++;
    if (o_tx_data !== 32'h0 || o_ch_rdy !== 3'b000 || o_cur_ch !== 2'd0) begin
      n_err++;
      $display("[TB] FAIL reset_data: got data=%h rdy=%b ch=%0d, want 0/000/0", o_tx_data, o_ch_rdy, o_cur_ch);
    end
    check_counters("reset");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_single_channel();
    int start;
    do_reset();
    push_pkt(1, 4, 32'hA0, 1'b1);
    expect_pkt(1, 4, 32'hA0);
    drive_inputs();
    start         = cyc;
    first_sop_cyc = -1;
    run_until_drained(20, "single");
    n_cmp++;
    if (first_sop_cyc !== start + 1) begin
      n_err++;
      $display("[TB] FAIL single_latency: got first beat at cyc %0d, want %0d", first_sop_cyc, start + 1);
    end
    check_counters("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      push_pkt(ch, 2, 32'h1000 * (ch + 1), 1'b1);
      push_pkt(ch, 2, 32'h1000 * (ch + 1) + 32'h10, 1'b1);
    end
    for (int p = 0; p < 2; p++) begin
      for (int ch = 0; ch < NUM_CH; ch++) expect_pkt(ch, 2, 32'h1000 * (ch + 1) + 32'(p * 16));
    end
    drive_inputs();
    run_until_drained(60, "rr");
    check_counters("rr");
  endtask

  task automatic test_back_to_back_backpressure();
    int budget;
    do_reset();
    push_pkt(2, 5, 32'hC0, 1'b1);
    expect_pkt(2, 5, 32'hC0);
    drive_inputs();
    toggle_rdy = 1'b1;
    budget     = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      sample();
      if (o_busy === 1'b1) begin
        n_cmp++;
        if (o_ch_rdy !== {i_tx_rdy, 2'b00}) begin
          n_err++;
          $display("[TB] FAIL bp_rdy: got %b, want %b", o_ch_rdy, {i_tx_rdy, 2'b00});
        end
      end
      advance();
      budget--;
    end
    toggle_rdy = 1'b0;
    i_tx_rdy   = 1'b1;
    run_until_drained(10, "bp");
    n_cmp++;
    if (src_q[2].size() != 0) begin
      n_err++;
      $display("[TB] FAIL bp_src_left: got %0d beats unaccepted, want 0", src_q[2].size());
    end
    check_counters("bp");
  endtask

  task automatic test_orphan_flush();
    beat_t b;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b.data = 32'hD0 + 32'(i);
      b.sop  = 1'b0;
      b.eop  = 1'b0;
      b.ch   = 2'd0;
      src_q[0].push_back(b);
    end
    drive_inputs();
    for (int i = 0; i < 3; i++) begin
      sample();
      n_cmp++;
      if (o_ch_rdy !== 3'b001 || o_tx_vld !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL orphan_rdy: got rdy=%b vld=%b, want rdy=001 vld=0", o_ch_rdy, o_tx_vld);
      end
      advance();
    end
    exp_drop += 3;
    check_counters("orphan");
  endtask

  task automatic test_single_beat();
    do_reset();
    push_pkt(0, 2, 32'h300, 1'b1);
    expect_pkt(0, 2, 32'h300);
    drive_inputs();
    run_until_drained(20, "sb_pre");
    push_pkt(0, 1, 32'h400, 1'b1);
    push_pkt(1, 1, 32'h401, 1'b1);
    expect_pkt(1, 1, 32'h401);
    expect_pkt(0, 1, 32'h400);
    drive_inputs();
    run_until_drained(20, "sb");
    check_counters("sb");
  endtask

  task automatic test_reset_mid_packet();
    int budget;
    int start;
    do_reset();
    push_pkt(0, 4, 32'h500, 1'b1);
    expect_pkt(0, 4, 32'h500);
    drive_inputs();
    budget = 20;
    while (exp_q.size() > 2 && budget > 0) begin
      sample();
      advance();
      budget--;
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_tx_vld !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midrst_outputs: got vld=%b busy=%b, want 0 0", o_tx_vld, o_busy);
    end
    do_reset();
    n_cmp++;
    if (o_cur_ch !== 2'd0) begin
      n_err++;
      $display("[TB] FAIL midrst_cur_ch: got %0d, want 0", o_cur_ch);
    end
    check_counters("midrst");
    push_pkt(0, 2, 32'h600, 1'b1);
    expect_pkt(0, 2, 32'h600);
    drive_inputs();
    start         = cyc;
    first_sop_cyc = -1;
    run_until_drained(20, "midrst_restart");
    n_cmp++;
    if (first_sop_cyc !== start + 1) begin
      n_err++;
      $display("[TB] FAIL midrst_latency: got first beat at cyc %0d, want %0d", first_sop_cyc, start + 1);
    end
    check_counters("midrst_restart");
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    cyc         = 0;
    exp_drop    = 0;
    gap_pending = 1'b0;
    toggle_rdy  = 1'b0;
    acc         = '0;
    for (int k = 0; k < NUM_CH; k++) exp_pkt[k] = 0;
    i_rst_n     = 1'b0;
    i_tx_rdy    = 1'b1;
    drive_inputs();

    $display("[TB] start");
    test_reset();
    test_single_channel();
    test_round_robin();
    test_back_to_back_backpressure();
    test_orphan_flush();
    test_single_beat();
    test_reset_mid_packet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
